// File: rtl/sch_cmd_seq_if.sv
// Scheduler command sequencer bus: manager request/response side plus the
// DFI command/data and read-return side, bundled into one interface.
interface sch_cmd_seq_if #(
  parameter int DIRAM_WIDTH = 32,
  parameter int PORT_NO     = 5,
  parameter int OCP_WIDTH   = DIRAM_WIDTH * 2,
  parameter int ADDR_W      = 12,
  parameter int BANK_W      = 2,
  parameter int BLOCK_W     = 4,
  parameter int TAG_W       = 4
);
  localparam int DW = OCP_WIDTH * PORT_NO;

  logic                dfi__sch__init_done;
  logic                mgr__sch__req_valid;
  logic                sch__mgr__req_ready;
  logic                mgr__sch__req_write;
  logic [BANK_W-1:0]   mgr__sch__req_bank;
  logic [ADDR_W-1:0]   mgr__sch__req_page;
  logic [BLOCK_W-1:0]  mgr__sch__req_block;
  logic [TAG_W-1:0]    mgr__sch__req_tag;
  logic [DW-1:0]       mgr__sch__req_wrdata;
  logic                sch__dfi__cs;
  logic                sch__dfi__cmd1;
  logic                sch__dfi__cmd0;
  logic [ADDR_W-1:0]   sch__dfi__addr;
  logic [BANK_W-1:0]   sch__dfi__bank;
  logic [DW-1:0]       sch__dfi__wrdata;
  logic [DW-1:0]       dfi__sch__rddata;
  logic                dfi__sch__rddata_valid;
  logic                sch__mgr__rsp_valid;
  logic [TAG_W-1:0]    sch__mgr__rsp_tag;
  logic [DW-1:0]       sch__mgr__rsp_data;
  logic                sch__mgr__err_unexp_rd;

  // Sequencer side
  modport slave (
    input  dfi__sch__init_done, mgr__sch__req_valid, mgr__sch__req_write,
           mgr__sch__req_bank, mgr__sch__req_page, mgr__sch__req_block,
           mgr__sch__req_tag, mgr__sch__req_wrdata,
           dfi__sch__rddata, dfi__sch__rddata_valid,
    output sch__mgr__req_ready, sch__dfi__cs, sch__dfi__cmd1, sch__dfi__cmd0,
           sch__dfi__addr, sch__dfi__bank, sch__dfi__wrdata,
           sch__mgr__rsp_valid, sch__mgr__rsp_tag, sch__mgr__rsp_data,
           sch__mgr__err_unexp_rd
  );

  // Manager / DFI side
  modport master (
    output dfi__sch__init_done, mgr__sch__req_valid, mgr__sch__req_write,
           mgr__sch__req_bank, mgr__sch__req_page, mgr__sch__req_block,
           mgr__sch__req_tag, mgr__sch__req_wrdata,
           dfi__sch__rddata, dfi__sch__rddata_valid,
    input  sch__mgr__req_ready, sch__dfi__cs, sch__dfi__cmd1, sch__dfi__cmd0,
           sch__dfi__addr, sch__dfi__bank, sch__dfi__wrdata,
           sch__mgr__rsp_valid, sch__mgr__rsp_tag, sch__mgr__rsp_data,
           sch__mgr__err_unexp_rd
  );
endinterface

// File: rtl/sch_cmd_seq.sv
// Scheduler command sequencer: buffers manager requests, opens pages per
// bank, spaces commands by tRCD/tWTR and returns read data in issue order.
module sch_cmd_seq #(
  parameter int DIRAM_WIDTH = 32,
  parameter int PORT_NO     = 5,
  parameter int OCP_WIDTH   = DIRAM_WIDTH * 2,
  parameter int ADDR_W      = 12,
  parameter int BANK_W      = 2,
  parameter int BLOCK_W     = 4,
  parameter int TAG_W       = 4,
  parameter int REQ_DEPTH   = 4,
  parameter int MAX_RD      = 4,
  parameter int T_RCD       = 3,
  parameter int T_WTR       = 2
) (
  input  logic         clk,
  input  logic         reset,
  sch_cmd_seq_if.slave bus
);
  localparam int DW    = OCP_WIDTH * PORT_NO;
  localparam int NBANK = 2 ** BANK_W;
  localparam int FP_W  = $clog2(REQ_DEPTH);
  localparam int TQ_W  = $clog2(MAX_RD);
  localparam int TM_W  = $clog2(((T_RCD > T_WTR) ? T_RCD : T_WTR) + 1);

  localparam logic [FP_W:0]   FIFO_FULL = (FP_W+1)'(REQ_DEPTH);
  localparam logic [FP_W:0]   FIFO_ONE  = (FP_W+1)'(1);
  localparam logic [TQ_W:0]   TQ_FULL   = (TQ_W+1)'(MAX_RD);
  localparam logic [TM_W-1:0] RCD_LD    = TM_W'(T_RCD - 1);
  localparam logic [TM_W-1:0] WTR_LD    = TM_W'(T_WTR);

  localparam logic [1:0] CMD_NOP = 2'b00;
  localparam logic [1:0] CMD_ACT = 2'b01;
  localparam logic [1:0] CMD_WR  = 2'b10;
  localparam logic [1:0] CMD_RD  = 2'b11;

  typedef struct packed {
    logic               wr;
    logic [BANK_W-1:0]  bank;
    logic [ADDR_W-1:0]  page;
    logic [BLOCK_W-1:0] block;
    logic [TAG_W-1:0]   tag;
    logic [DW-1:0]      data;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_ACT, S_WAIT, S_ACCESS} state_e;

  // ---------------- request FIFO ----------------
  req_t              fifo_q [REQ_DEPTH];
  req_t              wreq, head;
  logic [FP_W-1:0]   wp_q, rp_q, rp_nx;
  logic [FP_W:0]     fcnt_q, fcnt_d;
  logic              rdy_q, push, pop;
  logic              nxt_wr;
  logic [BANK_W-1:0] nxt_bank;
  logic [ADDR_W-1:0] nxt_page;

  assign wreq.wr    = bus.mgr__sch__req_write;
  assign wreq.bank  = bus.mgr__sch__req_bank;
  assign wreq.page  = bus.mgr__sch__req_page;
  assign wreq.block = bus.mgr__sch__req_block;
  assign wreq.tag   = bus.mgr__sch__req_tag;
  assign wreq.data  = bus.mgr__sch__req_wrdata;

  assign push     = bus.mgr__sch__req_valid & rdy_q;
  assign rp_nx    = rp_q + 1'b1;
  assign head     = fifo_q[rp_q];
  assign nxt_wr   = fifo_q[rp_nx].wr;
  assign nxt_bank = fifo_q[rp_nx].bank;
  assign nxt_page = fifo_q[rp_nx].page;

  // FIFO occupancy next-state
  always_comb begin
    fcnt_d = fcnt_q;
    if (push && !pop)      fcnt_d = fcnt_q + 1'b1;
    else if (pop && !push) fcnt_d = fcnt_q - 1'b1;
  end

  // FIFO pointers; ready is a registered not-full flag, low through reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_q   <= '0;
      rp_q   <= '0;
      fcnt_q <= '0;
      rdy_q  <= 1'b0;
    end else begin
      if (push) wp_q <= wp_q + 1'b1;
      if (pop)  rp_q <= rp_nx;
      fcnt_q <= fcnt_d;
      rdy_q  <= (fcnt_d != FIFO_FULL);
    end
  end

  // FIFO storage; pointers alone define what is valid
  always_ff @(posedge clk) begin
    if (push) fifo_q[wp_q] <= wreq;
  end

  // ---------------- open pages, timers, tag queue ----------------
  logic [NBANK-1:0]             pv_q;
  logic [NBANK-1:0][ADDR_W-1:0] pg_q;
  logic [NBANK-1:0][TM_W-1:0]   trcd_q;
  logic [TM_W-1:0]              twtr_q;
  logic [TAG_W-1:0]             tq_mem [MAX_RD];
  logic [TQ_W-1:0]              tq_wp_q, tq_rp_q;
  logic [TQ_W:0]                tq_cnt_q;
  logic                         rd_pop, unexp;
  logic                         head_hit, nxt_hit, rd_ok, head_ok, nxt_ok, b2b;

  assign head_hit = pv_q[head.bank] && (pg_q[head.bank] == head.page);
  assign nxt_hit  = pv_q[nxt_bank]  && (pg_q[nxt_bank]  == nxt_page);
  assign rd_ok    = (tq_cnt_q < TQ_FULL) && (twtr_q == '0);
  assign head_ok  = head.wr || rd_ok;
  // A following read may chain only behind a read (no tWTR reload) and
  // only if the tag slot taken by the current read still leaves room.
  assign nxt_ok   = nxt_wr || (!head.wr && (twtr_q == '0) &&
                               (tq_cnt_q < (TQ_FULL - 1'b1)));
  assign b2b      = (fcnt_q > FIFO_ONE) && nxt_hit && nxt_ok;

  assign rd_pop = bus.dfi__sch__rddata_valid && (tq_cnt_q != '0);
  assign unexp  = bus.dfi__sch__rddata_valid && (tq_cnt_q == '0);

  // ---------------- command FSM ----------------
  state_e            state_q, state_d;
  logic              cs_d, act_go, wr_go, rd_push, trcd_ld;
  logic [1:0]        cmd_d;
  logic [ADDR_W-1:0] addr_d;
  logic [BANK_W-1:0] bank_d;
  logic [DW-1:0]     wd_d;

  // Next state and the command to register this cycle
  always_comb begin
    state_d = state_q;
    cs_d    = 1'b0;
    cmd_d   = CMD_NOP;
    addr_d  = '0;
    bank_d  = '0;
    wd_d    = '0;
    pop     = 1'b0;
    act_go  = 1'b0;
    wr_go   = 1'b0;
    rd_push = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fcnt_q != '0 && bus.dfi__sch__init_done)
          state_d = (head_hit && head_ok) ? S_ACCESS : S_ACT;
      end
      S_ACT: begin
        if (bus.dfi__sch__init_done) begin
          cs_d    = 1'b1;
          cmd_d   = CMD_ACT;
          addr_d  = head.page;
          bank_d  = head.bank;
          act_go  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.dfi__sch__init_done && trcd_q[head.bank] == '0 && head_ok)
          state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (bus.dfi__sch__init_done) begin
          cs_d    = 1'b1;
          cmd_d   = head.wr ? CMD_WR : CMD_RD;
          addr_d  = ADDR_W'(head.block);
          bank_d  = head.bank;
          wd_d    = head.wr ? head.data : '0;
          pop     = 1'b1;
          wr_go   = head.wr;
          rd_push = !head.wr;
          state_d = b2b ? S_ACCESS : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // tRCD is (re)loaded while heading into or holding in ACT, so it has
  // already ticked once by the edge that puts ACTIVATE on the bus.
  assign trcd_ld = (state_d == S_ACT);

  // FSM state and registered DFI command outputs
  logic              cs_q;
  logic [1:0]        cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BANK_W-1:0] bank_q;
  logic [DW-1:0]     wd_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cs_q    <= 1'b0;
      cmd_q   <= CMD_NOP;
      addr_q  <= '0;
      bank_q  <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      bank_q  <= bank_d;
      wd_q    <= wd_d;
    end
  end

  // Open-page table and per-bank tRCD / global tWTR timers (saturate at 0)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pv_q   <= '0;
      pg_q   <= '0;
      trcd_q <= '0;
      twtr_q <= '0;
    end else begin
      if (act_go) begin
        pv_q[head.bank] <= 1'b1;
        pg_q[head.bank] <= head.page;
      end
      for (int b = 0; b < NBANK; b++) begin
        if (trcd_ld && head.bank == BANK_W'(b)) trcd_q[b] <= RCD_LD;
        else if (trcd_q[b] != '0)               trcd_q[b] <= trcd_q[b] - 1'b1;
      end
      if (wr_go)               twtr_q <= WTR_LD;
      else if (twtr_q != '0)   twtr_q <= twtr_q - 1'b1;
    end
  end

  // In-order read tag queue pointers and count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tq_wp_q  <= '0;
      tq_rp_q  <= '0;
      tq_cnt_q <= '0;
    end else begin
      if (rd_push) tq_wp_q <= tq_wp_q + 1'b1;
      if (rd_pop)  tq_rp_q <= tq_rp_q + 1'b1;
      if (rd_push && !rd_pop)      tq_cnt_q <= tq_cnt_q + 1'b1;
      else if (rd_pop && !rd_push) tq_cnt_q <= tq_cnt_q - 1'b1;
    end
  end

  // Tag storage
  always_ff @(posedge clk) begin
    if (rd_push) tq_mem[tq_wp_q] <= head.tag;
  end

  // Registered response and sticky unexpected-read-data flag
  logic             rsp_v_q, err_q;
  logic [TAG_W-1:0] rsp_tag_q;
  logic [DW-1:0]    rsp_data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_v_q    <= 1'b0;
      rsp_tag_q  <= '0;
      rsp_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      rsp_v_q    <= rd_pop;
      rsp_tag_q  <= rd_pop ? tq_mem[tq_rp_q] : '0;
      rsp_data_q <= rd_pop ? bus.dfi__sch__rddata : '0;
      err_q      <= err_q | unexp;
    end
  end

  assign bus.sch__mgr__req_ready    = rdy_q;
  assign bus.sch__dfi__cs           = cs_q;
  assign bus.sch__dfi__cmd1         = cmd_q[1];
  assign bus.sch__dfi__cmd0         = cmd_q[0];
  assign bus.sch__dfi__addr         = addr_q;
  assign bus.sch__dfi__bank         = bank_q;
  assign bus.sch__dfi__wrdata       = wd_q;
  assign bus.sch__mgr__rsp_valid    = rsp_v_q;
  assign bus.sch__mgr__rsp_tag      = rsp_tag_q;
  assign bus.sch__mgr__rsp_data     = rsp_data_q;
  assign bus.sch__mgr__err_unexp_rd = err_q;
endmodule

// File: tb/tb_sch_cmd_seq.sv
// Directed bench for sch_cmd_seq: command encoding, tRCD/tWTR spacing,
// page hits, read-tag limit, in-order responses, error flag and reset.
module tb_sch_cmd_seq;
  localparam int DW = 320;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sch_cmd_seq_if bus ();
  sch_cmd_seq dut (.clk(clk), .reset(rst_n), .bus(bus));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int            cyc;
    logic [1:0]    cmd;
    logic [11:0]   addr;
    logic [1:0]    bank;
    logic [DW-1:0] wd;
  } cmd_t;

  cmd_t cq[$];
  bit   mon_en = 0;

  // Log every issued command; idle cycles must drive all-zero fields
  always @(negedge clk) begin
    cmd_t e;
    if (mon_en) begin
      if (bus.sch__dfi__cs) begin
        e.cyc  = cyc;
        e.cmd  = {bus.sch__dfi__cmd1, bus.sch__dfi__cmd0};
        e.addr = bus.sch__dfi__addr;
        e.bank = bus.sch__dfi__bank;
        e.wd   = bus.sch__dfi__wrdata;
        cq.push_back(e);
      end else begin
        chk("nop_zero", DW'({bus.sch__dfi__cmd1, bus.sch__dfi__cmd0, bus.sch__dfi__addr,
                             bus.sch__dfi__bank, |bus.sch__dfi__wrdata}), '0);
      end
    end
  end

  function automatic int ncmd(input logic [1:0] c);
    int k = 0;
    foreach (cq[i]) if (cq[i].cmd == c) k++;
    return k;
  endfunction

  task automatic send(input bit wr, input logic [1:0] bank, input logic [11:0] page,
                      input logic [3:0] blk, input logic [3:0] tag,
                      input logic [DW-1:0] d, output int acc);
    int n = 0;
    bus.mgr__sch__req_valid  = 1'b1;
    bus.mgr__sch__req_write  = wr;
    bus.mgr__sch__req_bank   = bank;
    bus.mgr__sch__req_page   = page;
    bus.mgr__sch__req_block  = blk;
    bus.mgr__sch__req_tag    = tag;
    bus.mgr__sch__req_wrdata = d;
    while (!bus.sch__mgr__req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("req_ready_seen", DW'(n < 50), DW'(1));
    @(posedge clk); #1;
    acc = cyc;
    bus.mgr__sch__req_valid = 1'b0;
  endtask

  // Wait (bounded) for the n-th command of type c; idx is its log position
  task automatic wait_cmd(input logic [1:0] c, input int n, output int idx);
    int k;
    idx = -1;
    for (int t = 0; t < 60 && idx < 0; t++) begin
      k = 0;
      foreach (cq[i]) if (cq[i].cmd == c) begin
        k++;
        if (k == n && idx < 0) idx = i;
      end
      if (idx < 0) begin @(posedge clk); #2; end
    end
    chk($sformatf("wait_cmd%0d_n%0d", c, n), DW'(idx >= 0), DW'(1));
    if (idx < 0) idx = 0;
  endtask

  // One-cycle read-data return; response checked one cycle later
  task automatic rd_ret(input logic [DW-1:0] d, input bit exp_v,
                        input logic [3:0] exp_tag, input string nm);
    @(negedge clk);
    bus.dfi__sch__rddata       = d;
    bus.dfi__sch__rddata_valid = 1'b1;
    @(negedge clk);
    bus.dfi__sch__rddata_valid = 1'b0;
    bus.dfi__sch__rddata       = '0;
    chk($sformatf("%s_valid", nm), DW'(bus.sch__mgr__rsp_valid), DW'(exp_v));
    if (exp_v) begin
      chk($sformatf("%s_tag", nm), DW'(bus.sch__mgr__rsp_tag), DW'(exp_tag));
      chk($sformatf("%s_data", nm), bus.sch__mgr__rsp_data, d);
    end
  endtask

  logic [DW-1:0] d1, d2, d3, d4, r1;

  initial begin
    int a, i0, i1;
    d1 = {10{32'hA5A5_0003}};
    d2 = {10{32'h5A5A_0004}};
    d3 = {10{32'hCAFE_0005}};
    d4 = {10{32'hBEEF_0007}};
    r1 = {10{32'h1234_5678}};
    bus.dfi__sch__init_done    = 1'b0;
    bus.mgr__sch__req_valid    = 1'b0;
    bus.mgr__sch__req_write    = 1'b0;
    bus.mgr__sch__req_bank     = '0;
    bus.mgr__sch__req_page     = '0;
    bus.mgr__sch__req_block    = '0;
    bus.mgr__sch__req_tag      = '0;
    bus.mgr__sch__req_wrdata   = '0;
    bus.dfi__sch__rddata       = '0;
    bus.dfi__sch__rddata_valid = 1'b0;

    // Reset for 3 cycles: everything low, ready only after the first edge
    repeat (3) @(negedge clk);
    chk("rst_ready", DW'(bus.sch__mgr__req_ready), '0);
    chk("rst_cs", DW'(bus.sch__dfi__cs), '0);
    chk("rst_cmd", DW'({bus.sch__dfi__cmd1, bus.sch__dfi__cmd0, bus.sch__dfi__addr, bus.sch__dfi__bank}), '0);
    chk("rst_wrdata", bus.sch__dfi__wrdata, '0);
    chk("rst_rsp", DW'({bus.sch__mgr__rsp_valid, bus.sch__mgr__rsp_tag}), '0);
    chk("rst_rspdata", bus.sch__mgr__rsp_data, '0);
    chk("rst_err", DW'(bus.sch__mgr__err_unexp_rd), '0);
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", DW'(bus.sch__mgr__req_ready), '0);
    @(posedge clk); #1;
    chk("ready_after_edge", DW'(bus.sch__mgr__req_ready), DW'(1));
    bus.dfi__sch__init_done = 1'b1;
    mon_en = 1;

    // Miss: ACTIVATE two cycles after accept, WRITE exactly tRCD later
    cq.delete();
    send(1'b1, 2'd1, 12'h0A5, 4'd3, 4'd2, d1, a);
    wait_cmd(2'b10, 1, i1);
    chk("t1_act_cmd", DW'(cq[0].cmd), DW'(2'b01));
    chk("t1_act_addr", DW'(cq[0].addr), DW'(12'h0A5));
    chk("t1_act_bank", DW'(cq[0].bank), DW'(1));
    chk("t1_act_lat", DW'(cq[0].cyc - a), DW'(2));
    chk("t1_wr_addr", DW'(cq[i1].addr), DW'(3));
    chk("t1_wr_bank", DW'(cq[i1].bank), DW'(1));
    chk("t1_wr_data", cq[i1].wd, d1);
    chk("t1_trcd", DW'(cq[i1].cyc - cq[0].cyc), DW'(3));
    repeat (4) @(posedge clk); #1;

    // Page hit: WRITE two cycles after accept, no ACTIVATE
    cq.delete();
    send(1'b1, 2'd1, 12'h0A5, 4'd4, 4'd3, d2, a);
    wait_cmd(2'b10, 1, i1);
    repeat (6) @(posedge clk); #1;
    chk("t2_ncmd", DW'(cq.size()), DW'(1));
    chk("t2_lat", DW'(cq[i1].cyc - a), DW'(2));
    chk("t2_addr", DW'(cq[i1].addr), DW'(4));
    chk("t2_data", cq[i1].wd, d2);

    // WRITE then READ on the open page: tWTR spacing, tagged response
    cq.delete();
    send(1'b1, 2'd1, 12'h0A5, 4'd5, 4'd4, d3, a);
    send(1'b0, 2'd1, 12'h0A5, 4'd6, 4'd5, '0, a);
    wait_cmd(2'b11, 1, i1);
    wait_cmd(2'b10, 1, i0);
    chk("t3_wr_addr", DW'(cq[i0].addr), DW'(5));
    chk("t3_rd_addr", DW'(cq[i1].addr), DW'(6));
    chk("t3_rd_bank", DW'(cq[i1].bank), DW'(1));
    chk("t3_wtr_gap", DW'((cq[i1].cyc - cq[i0].cyc) >= 2), DW'(1));
    chk("t3_rd_wd_zero", cq[i1].wd, '0);
    rd_ret(r1, 1'b1, 4'd5, "t3_rsp");
    @(negedge clk);
    chk("t3_rsp_single", DW'(bus.sch__mgr__rsp_valid), '0);
    repeat (4) @(posedge clk); #1;

    // Five reads: four issue, the fifth waits for a tag slot
    cq.delete();
    for (int k = 0; k < 5; k++) send(1'b0, 2'd1, 12'h0A5, 4'(k), 4'(8 + k), '0, a);
    repeat (20) @(posedge clk); #1;
    chk("t4_held", DW'(ncmd(2'b11)), DW'(4));
    rd_ret({10{32'hC0DE_0000}}, 1'b1, 4'd8, "t4_rsp0");
    wait_cmd(2'b11, 5, i1);
    chk("t4_rd5_addr", DW'(cq[i1].addr), DW'(4));
    for (int k = 1; k < 5; k++)
      rd_ret({10{32'hC0DE_0000 + 32'(k)}}, 1'b1, 4'(8 + k), $sformatf("t4_rsp%0d", k));

    // Read data with nothing outstanding: sticky error, no response
    rd_ret({10{32'hDEAD_0000}}, 1'b0, 4'd0, "t5_unexp");
    chk("t5_err_set", DW'(bus.sch__mgr__err_unexp_rd), DW'(1));
    repeat (3) @(negedge clk);
    chk("t5_err_sticky", DW'(bus.sch__mgr__err_unexp_rd), DW'(1));
    chk("t5_no_rsp", DW'(bus.sch__mgr__rsp_valid), '0);

    // Async reset while waiting out tRCD, then the page must miss again
    cq.delete();
    send(1'b1, 2'd2, 12'h155, 4'd7, 4'd6, d4, a);
    wait_cmd(2'b01, 1, i0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_err", DW'(bus.sch__mgr__err_unexp_rd), '0);
    chk("t6_rst_ready", DW'(bus.sch__mgr__req_ready), '0);
    chk("t6_rst_cs", DW'(bus.sch__dfi__cs), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    cq.delete();
    send(1'b0, 2'd2, 12'h155, 4'd8, 4'd9, '0, a);
    wait_cmd(2'b11, 1, i1);
    chk("t6_miss_act", DW'(cq[0].cmd), DW'(2'b01));
    chk("t6_act_page", DW'(cq[0].addr), DW'(12'h155));
    chk("t6_rd_addr", DW'(cq[i1].addr), DW'(8));
    chk("t6_dropped_wr", DW'(ncmd(2'b10)), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
